// File: rtl/rom_fetch_arbiter.sv
// Two-requester ROM fetch arbiter with m1 lock, starvation guard and one-cycle read latency.
// Define ROM_ARB_ROUND_ROBIN_EN to resolve contention in favour of the non-owner.
module rom_fetch_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    localparam int unsigned      CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_t;

    own_t             state_q, state_d;
    logic [CNT_W-1:0] wait0_q, wait1_q;
    logic             lock_resume_q;
    logic             g0, g1;
    logic             force0, force1, lock_act;

    assign force0   = m0_req && (wait0_q >= WAIT_MAX);
    assign force1   = m1_req && (wait1_q >= WAIT_MAX);
    // A starvation grant to m0 must not cost m1 its lock on the following cycle.
    assign lock_act = m1_req && m1_lock && ((state_q == OWN1) || lock_resume_q);

    // State register plus wait counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wait0_q       <= '0;
            wait1_q       <= '0;
            lock_resume_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_resume_q <= g0 && lock_act;
            if (m0_req && !g0)
                wait0_q <= (wait0_q >= WAIT_MAX) ? wait0_q : wait0_q + CNT_W'(1);
            else
                wait0_q <= '0;
            if (m1_req && !g1)
                wait1_q <= (wait1_q >= WAIT_MAX) ? wait1_q : wait1_q + CNT_W'(1);
            else
                wait1_q <= '0;
        end
    end

    // Next owner.
    always_comb begin
        state_d = state_q;
        if (g0)
            state_d = OWN0;
        else if (g1)
            state_d = OWN1;
        else if (!m0_req && !m1_req)
            state_d = IDLE;
    end

    // Grant decision.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (force0 && force1) begin
            if (state_q == OWN0) g1 = 1'b1;
            else                 g0 = 1'b1;
        end else if (force0) begin
            g0 = 1'b1;
        end else if (force1) begin
            g1 = 1'b1;
        end else if (lock_act) begin
            g1 = 1'b1;
        end else if (m0_req && m1_req) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
            if (state_q == OWN0) g1 = 1'b1;
            else                 g0 = 1'b1;
`else
            g0 = 1'b1;
`endif
        end else begin
            g0 = m0_req;
            g1 = m1_req;
        end
    end

    assign m0_gnt   = g0 & rst_n;
    assign m1_gnt   = g1 & rst_n;
    assign rom_ce   = (g0 | g1) & rst_n;
    assign rom_addr = !rst_n ? '0 : (g0 ? m0_addr : (g1 ? m1_addr : '0));

    // Read data capture on the grant edge; rdata holds when no new read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= g0;
            m1_rvalid <= g1;
            if (g0) m0_rdata <= rom_inst;
            if (g1) m1_rdata <= rom_inst;
        end
    end

endmodule
